// File: rtl/polar_pkg.sv
// polar_pkg
//   Definitions shared by the polar-code frozen-bit insertion and
//   extraction blocks.
//
//   extract_state_t : control states of the frozen-bit extractor
//   idx_w(n)        : width of one sorted_indexes entry for code length n
//                     ($clog2(n) position bits plus one spare bit)

package polar_pkg;

    typedef enum logic [1:0] {
        UNCFG   = 2'd0,
        MAP     = 2'd1,
        COLLECT = 2'd2,
        OUT     = 2'd3
    } extract_state_t;

    function automatic int idx_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/frozen_rank_table.sv
// frozen_rank_table
//   Holds a snapshot of the reliability-sorted index list and derives,
//   for every code position p, its reliability rank (0 = most reliable)
//   and whether it carries an information bit (rank < K). The table is
//   built by an N-cycle sequencer, one sorted entry per cycle.
//
// Ports
//   clk, rst_n      : clock, asynchronous active-low reset
//   load            : one-cycle pulse, snapshot sorted_indexes and rebuild
//   sorted_indexes  : N entries of IW bits, [N-1] is the most reliable
//   busy            : table build in progress
//   last            : busy cycle that writes the final entry
//   lookup_pos      : code position to look up
//   lookup_rank     : rank of lookup_pos (combinational)
//   lookup_info     : lookup_pos is an information position (combinational)

module frozen_rank_table
    import polar_pkg::*;
#(
    parameter int N  = 32,
    parameter int K  = 16,
    parameter int IW = idx_w(N),
    localparam int RW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [IW-1:0] sorted_indexes [N],
    output logic          busy,
    output logic          last,
    input  logic [RW-1:0] lookup_pos,
    output logic [RW-1:0] lookup_rank,
    output logic          lookup_info
);

    localparam logic [RW-1:0] JMAX = RW'(N - 1);
    localparam logic [RW:0]   KLIM = (RW + 1)'(K);

    logic [IW-1:0] snap [N];
    logic [RW-1:0] rank_tbl [N];
    logic [N-1:0]  info_tbl;
    logic [RW-1:0] j;
    logic [RW-1:0] sel;
    logic [IW-1:0] sel_idx;
    logic [RW-1:0] p;
    logic          unused_sel_msb;

    // Step j walks the snapshot from the most reliable entry downwards,
    // so the j-th visited position gets rank j. Only the low position bits
    // of each entry address the table; the spare top bit is ignored.
    assign sel            = JMAX - j;
    assign sel_idx        = snap[sel];
    assign p              = sel_idx[RW-1:0];
    assign unused_sel_msb = sel_idx[IW-1];
    assign last           = busy && (j == JMAX);

    assign lookup_rank = rank_tbl[lookup_pos];
    assign lookup_info = info_tbl[lookup_pos];

    // A load clears the info flags so a malformed list (duplicates) leaves
    // untouched positions frozen rather than stale from an older table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            j        <= '0;
            info_tbl <= '0;
            for (int i = 0; i < N; i++) begin
                snap[i]     <= '0;
                rank_tbl[i] <= '0;
            end
        end else if (load) begin
            busy     <= 1'b1;
            j        <= '0;
            info_tbl <= '0;
            for (int i = 0; i < N; i++) begin
                snap[i] <= sorted_indexes[i];
            end
        end else if (busy) begin
            rank_tbl[p] <= j;
            info_tbl[p] <= ({1'b0, j} < KLIM);
            if (j == JMAX) begin
                busy <= 1'b0;
            end else begin
                j <= j + 1'b1;
            end
        end
    end

endmodule

// File: rtl/frozen_extract.sv
// frozen_extract
//   Receiver-side frozen-bit removal for a polar decoder. Accepts the N
//   decoded u-hat bits of a frame serially in natural index order, keeps
//   the K information bits in data order (data[i] comes from position
//   sorted_indexes[N-1-i]) and flags any frozen position decoded as 1.
//   Single frame buffer: a frame is presented until the sink takes it.
//
// Ports
//   clk, rst_n      : clock, asynchronous active-low reset
//   cfg_load        : pulse, capture sorted_indexes and rebuild the table
//                     (honoured only when unconfigured or between frames)
//   sorted_indexes  : N entries of IW bits, ascending reliability
//   cfg_busy        : table build in progress
//   in_valid/in_ready/in_bit : serial u-hat input handshake
//   out_valid/out_ready      : frame output handshake
//   out_data        : K extracted information bits, data order
//   frozen_err      : some frozen position of the frame was 1

module frozen_extract
    import polar_pkg::*;
#(
    parameter int N  = 32,
    parameter int K  = 16,
    parameter int IW = idx_w(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_load,
    input  logic [IW-1:0] sorted_indexes [N],
    output logic          cfg_busy,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_bit,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [K-1:0]  out_data,
    output logic          frozen_err
);

    localparam int RW = $clog2(N);
    localparam logic [RW-1:0] CMAX = RW'(N - 1);

    extract_state_t state, state_next;

    logic [RW-1:0] cnt;
    logic [K-1:0]  data_buf;
    logic [K-1:0]  buf_next;
    logic          err_acc;
    logic          tbl_load;
    logic          tbl_busy;
    logic          tbl_last;
    logic [RW-1:0] cur_rank;
    logic          cur_info;
    logic          accept;
    logic          frame_done;
    logic          frozen_one;

    frozen_rank_table #(
        .N  (N),
        .K  (K),
        .IW (IW)
    ) u_rank_table (
        .clk            (clk),
        .rst_n          (rst_n),
        .load           (tbl_load),
        .sorted_indexes (sorted_indexes),
        .busy           (tbl_busy),
        .last           (tbl_last),
        .lookup_pos     (cnt),
        .lookup_rank    (cur_rank),
        .lookup_info    (cur_info)
    );

    // Reconfiguration is only allowed at a frame boundary. A load on the
    // first bit slot takes priority, so in_ready drops for that cycle and
    // no bit is silently lost.
    assign tbl_load   = cfg_load && ((state == UNCFG) ||
                                     ((state == COLLECT) && (cnt == '0)));
    assign in_ready   = (state == COLLECT) && !tbl_load;
    assign out_valid  = (state == OUT);
    assign cfg_busy   = tbl_busy;
    assign accept     = in_valid && in_ready;
    assign frame_done = accept && (cnt == CMAX);
    assign frozen_one = !cur_info && in_bit;

    always_comb begin
        state_next = state;
        case (state)
            UNCFG:   if (tbl_load) state_next = MAP;
            MAP:     if (tbl_last) state_next = COLLECT;
            COLLECT: begin
                if (tbl_load) begin
                    state_next = MAP;
                end else if (frame_done) begin
                    state_next = OUT;
                end
            end
            OUT:     if (out_ready) state_next = COLLECT;
            default: state_next = UNCFG;
        endcase
    end

    // The incoming bit is merged into the buffer here so the final bit of
    // a frame can go straight to out_data on the completing accept.
    always_comb begin
        buf_next = data_buf;
        for (int i = 0; i < K; i++) begin
            if (cur_info && (cur_rank == RW'(i))) begin
                buf_next[i] = in_bit;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= UNCFG;
            cnt        <= '0;
            data_buf   <= '0;
            err_acc    <= 1'b0;
            out_data   <= '0;
            frozen_err <= 1'b0;
        end else begin
            state <= state_next;
            if (tbl_load) begin
                cnt     <= '0;
                err_acc <= 1'b0;
            end else if (accept) begin
                data_buf <= buf_next;
                if (frame_done) begin
                    cnt        <= '0;
                    err_acc    <= 1'b0;
                    out_data   <= buf_next;
                    frozen_err <= err_acc | frozen_one;
                end else begin
                    cnt     <= cnt + 1'b1;
                    err_acc <= err_acc | frozen_one;
                end
            end
        end
    end

endmodule

// File: tb/tb_frozen_extract.sv
// tb_frozen_extract
//   Directed bench for frozen_extract: a small N=8/K=4 instance for the
//   hand-computed vectors and an N=32/K=16 instance for the roundtrip
//   against a frozen-insertion model.

module tb_frozen_extract;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       cfg_load8, in_valid8, in_bit8, out_ready8;
    logic [3:0] sorted8 [8];
    logic       cfg_busy8, in_ready8, out_valid8, frozen_err8;
    logic [3:0] out_data8;

    logic        cfg_load32, in_valid32, in_bit32, out_ready32;
    logic [5:0]  sorted32 [32];
    logic [5:0]  perm32 [32];
    logic        cfg_busy32, in_ready32, out_valid32, frozen_err32;
    logic [15:0] out_data32;

    int n_checks = 0;
    int n_fail   = 0;

    frozen_extract #(.N(8), .K(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load8), .sorted_indexes(sorted8),
        .cfg_busy(cfg_busy8), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_bit(in_bit8), .out_valid(out_valid8), .out_ready(out_ready8),
        .out_data(out_data8), .frozen_err(frozen_err8)
    );

    frozen_extract #(.N(32), .K(16)) dut32 (
        .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load32), .sorted_indexes(sorted32),
        .cfg_busy(cfg_busy32), .in_valid(in_valid32), .in_ready(in_ready32),
        .in_bit(in_bit32), .out_valid(out_valid32), .out_ready(out_ready32),
        .out_data(out_data32), .frozen_err(frozen_err32)
    );

    task automatic config8(output int busy_cycles, output logic rdy_after);
        @(negedge clk); cfg_load8 = 1'b1;
        @(negedge clk); cfg_load8 = 1'b0;
        busy_cycles = 0;
        for (int c = 0; c < 100 && cfg_busy8; c++) begin
            busy_cycles++;
            @(negedge clk);
        end
        rdy_after = in_ready8;
    endtask

    // Streams u[0..nbits-1]; returns right after the posedge of the last accept.
    task automatic stream8(input logic [7:0] u, input int nbits, input bit gaps,
                           output bit timeout);
        int  idx = 0;
        int  cyc = 0;
        bit  acc;
        while (idx < nbits && cyc < 200) begin
            @(negedge clk);
            in_valid8 = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_bit8   = u[idx];
            acc       = in_valid8 && in_ready8;
            @(posedge clk);
            if (acc) idx++;
            cyc++;
        end
        timeout = (idx < nbits);
    endtask

    task automatic release8();
        @(negedge clk); out_ready8 = 1'b1;
        @(negedge clk); out_ready8 = 1'b0;
    endtask

    // Runs one 8-bit frame and checks the presented result, then hands it off.
    task automatic frame8(input string name, input logic [7:0] u, input bit gaps,
                          input logic [3:0] exp_data, input logic exp_err);
        bit to;
        stream8(u, 8, gaps, to);
        n_checks++; if (to) begin n_fail++; $display("[TB] FAIL %s_timeout: accepted fewer than 8 bits", name); end
        @(negedge clk); in_valid8 = 1'b0;
        n_checks++; if (out_valid8 !== 1'b1) begin n_fail++; $display("[TB] FAIL %s_valid: got %b expected 1", name, out_valid8); end
        n_checks++; if (out_data8 !== exp_data) begin n_fail++; $display("[TB] FAIL %s_data: got %b expected %b", name, out_data8, exp_data); end
        n_checks++; if (frozen_err8 !== exp_err) begin n_fail++; $display("[TB] FAIL %s_err: got %b expected %b", name, frozen_err8, exp_err); end
        release8();
        n_checks++; if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin n_fail++; $display("[TB] FAIL %s_release: got valid=%b ready=%b expected valid=0 ready=1", name, out_valid8, in_ready8); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cfg_load8 = 0; in_valid8 = 0; in_bit8 = 0; out_ready8 = 0;
        cfg_load32 = 0; in_valid32 = 0; in_bit32 = 0; out_ready32 = 0;
        for (int i = 0; i < 8; i++) sorted8[i] = '0;
        for (int i = 0; i < 32; i++) sorted32[i] = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if ({in_ready8, out_valid8, cfg_busy8, frozen_err8} !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_flags8: got %b expected 0000", {in_ready8, out_valid8, cfg_busy8, frozen_err8}); end
        n_checks++; if (out_data8 !== 4'h0) begin n_fail++; $display("[TB] FAIL reset_data8: got %h expected 0", out_data8); end
        n_checks++; if ({in_ready32, out_valid32, cfg_busy32, frozen_err32} !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_flags32: got %b expected 0000", {in_ready32, out_valid32, cfg_busy32, frozen_err32}); end
        n_checks++; if (out_data32 !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_data32: got %h expected 0", out_data32); end
    endtask

    task automatic test_config_map();
        int   bc;
        logic rdy;
        sorted8 = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd3, 4'd5, 4'd6, 4'd7};
        config8(bc, rdy);
        n_checks++; if (bc != 8) begin n_fail++; $display("[TB] FAIL map_busy_cycles: got %0d expected 8", bc); end
        n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("[TB] FAIL map_ready_after: got %b expected 1", rdy); end
    endtask

    task automatic test_basic_frame();
        // u3,u5,u7 set: data[0]=u7=1, data[1]=u6=0, data[2]=u5=1, data[3]=u3=1
        frame8("basic", 8'hA8, 1'b0, 4'b1101, 1'b0);
    endtask

    task automatic test_frozen_violation();
        frame8("frozen_viol", 8'hA9, 1'b0, 4'b1101, 1'b1);
        n_checks++; if (frozen_err8 !== 1'b1) begin n_fail++; $display("[TB] FAIL frozen_err_held: got %b expected 1", frozen_err8); end
        frame8("frozen_clean", 8'hA8, 1'b0, 4'b1101, 1'b0);
    endtask

    task automatic test_gaps();
        frame8("gaps_basic", 8'hA8, 1'b1, 4'b1101, 1'b0);
        // u0,u5,u6,u7 set: data = {u3,u5,u6,u7} = 0,1,1,1 ; u0 frozen
        frame8("gaps_e1", 8'hE1, 1'b1, 4'b0111, 1'b1);
    endtask

    task automatic test_backpressure();
        bit to;
        int bad = 0;
        stream8(8'h28, 8, 1'b0, to);
        n_checks++; if (to) begin n_fail++; $display("[TB] FAIL bp_timeout: accepted fewer than 8 bits"); end
        @(negedge clk);
        in_valid8 = 1'b1; in_bit8 = 1'b1; cfg_load8 = 1'b1;
        n_checks++; if (out_data8 !== 4'b1100) begin n_fail++; $display("[TB] FAIL bp_data: got %b expected 1100", out_data8); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            cfg_load8 = 1'b0;
            n_checks++;
            if (out_valid8 !== 1'b1 || in_ready8 !== 1'b0 || out_data8 !== 4'b1100 || cfg_busy8 !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL bp_hold: got valid=%b ready=%b data=%b busy=%b expected 1 0 1100 0", out_valid8, in_ready8, out_data8, cfg_busy8);
            end
        end
        in_valid8 = 1'b0;
        release8();
        n_checks++; if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_release: got valid=%b ready=%b expected 0 1", out_valid8, in_ready8); end
        // Bits offered while the frame was held must not have been counted.
        frame8("bp_next", 8'hA8, 1'b0, 4'b1101, 1'b0);
        if (bad != 0) n_fail++;
    endtask

    task automatic test_roundtrip32();
        int          bc;
        logic [15:0] d;
        logic [31:0] u;
        logic [5:0]  s;
        int          idx, cyc;
        bit          acc, pulse, gaps;
        for (int k = 0; k < 32; k++) begin
            perm32[k]   = 6'((k * 7 + 3) % 32);
            sorted32[k] = perm32[k];
        end
        @(negedge clk); cfg_load32 = 1'b1;
        @(negedge clk); cfg_load32 = 1'b0;
        bc = 0;
        for (int c = 0; c < 100 && cfg_busy32; c++) begin bc++; @(negedge clk); end
        n_checks++; if (bc != 32) begin n_fail++; $display("[TB] FAIL rt_busy_cycles: got %0d expected 32", bc); end
        n_checks++; if (in_ready32 !== 1'b1) begin n_fail++; $display("[TB] FAIL rt_ready_after: got %b expected 1", in_ready32); end
        for (int f = 0; f < 100; f++) begin
            d = 16'($urandom);
            u = '0;
            for (int i = 0; i < 16; i++) begin
                s = perm32[31 - i];
                u[s[4:0]] = d[i];
            end
            pulse = (f == 7);
            gaps  = f[0];
            idx = 0; cyc = 0;
            while (idx < 32 && cyc < 400) begin
                @(negedge clk);
                if (pulse && idx == 5) begin
                    for (int k = 0; k < 32; k++) sorted32[k] = 6'(31 - k);
                    cfg_load32 = 1'b1;
                    pulse = 1'b0;
                end else begin
                    cfg_load32 = 1'b0;
                end
                in_valid32 = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                in_bit32   = u[idx];
                acc        = in_valid32 && in_ready32;
                @(posedge clk);
                if (acc) idx++;
                cyc++;
            end
            @(negedge clk);
            in_valid32 = 1'b0; cfg_load32 = 1'b0;
            n_checks++; if (idx < 32 || out_valid32 !== 1'b1) begin n_fail++; $display("[TB] FAIL rt_valid frame %0d: got accepted=%0d valid=%b expected 32 1", f, idx, out_valid32); end
            n_checks++; if (out_data32 !== d) begin n_fail++; $display("[TB] FAIL rt_data frame %0d: got %h expected %h", f, out_data32, d); end
            n_checks++; if (frozen_err32 !== 1'b0 || cfg_busy32 !== 1'b0) begin n_fail++; $display("[TB] FAIL rt_err frame %0d: got err=%b busy=%b expected 0 0", f, frozen_err32, cfg_busy32); end
            @(negedge clk); out_ready32 = 1'b1;
            @(negedge clk); out_ready32 = 1'b0;
        end
    endtask

    task automatic test_reset_midframe();
        bit   to;
        int   bc;
        logic rdy;
        stream8(8'hFF, 3, 1'b0, to);
        @(negedge clk);
        in_valid8 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({in_ready8, out_valid8, cfg_busy8, frozen_err8} !== 4'b0000) begin n_fail++; $display("[TB] FAIL midreset_flags: got %b expected 0000", {in_ready8, out_valid8, cfg_busy8, frozen_err8}); end
        n_checks++; if (out_data8 !== 4'h0) begin n_fail++; $display("[TB] FAIL midreset_data: got %b expected 0000", out_data8); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready8 !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_uncfg: got ready=%b expected 0", in_ready8); end
        config8(bc, rdy);
        n_checks++; if (bc != 8 || rdy !== 1'b1) begin n_fail++; $display("[TB] FAIL midreset_reconfig: got busy=%0d ready=%b expected 8 1", bc, rdy); end
        // u3,u5,u6 set: data = {u3,u5,u6,u7} = 1,1,1,0 read as data[3..0]=1110
        frame8("after_reset", 8'h68, 1'b0, 4'b1110, 1'b0);
    endtask

    initial begin
        test_reset();
        test_config_map();
        test_basic_frame();
        test_frozen_violation();
        test_gaps();
        test_backpressure();
        test_roundtrip32();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
